// File: rtl/bus_pkg.sv
// Shared types and constants for the multiplexed-bus memory port.
package bus_pkg;
  localparam int unsigned ADDR_W_DEF = 20;
  localparam int unsigned MAX_WAIT   = 7;
  localparam logic        IOM_MEM    = 1'b1;
  localparam logic        IOM_IO     = 1'b0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_WAIT,
    S_DATA,
    S_HOLD
  } state_t;
endpackage

// File: rtl/bus_mem_port_if.sv
// Multiplexed ALE/RD/WR bus; AD is carried as master drive plus slave drive/enable,
// with the physical tristate resolved at the pad ring.
interface bus_mem_port_if
  import bus_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
);
  logic              ALE;
  logic              IOM;
  logic              RD;
  logic              WR;
  logic [ADDR_W-9:0] A;
  logic [7:0]        AD_i;
  logic [7:0]        AD_o;
  logic              AD_oe;
  logic              RDY;
  logic              ERR;

  modport slave (
    input  ALE, IOM, RD, WR, A, AD_i,
    output AD_o, AD_oe, RDY, ERR
  );

  modport master (
    output ALE, IOM, RD, WR, A, AD_i,
    input  AD_o, AD_oe, RDY, ERR
  );
endinterface

// File: rtl/bus_wait_timer.sv
// Wait-state down-counter: load a count, decrement on request, flag the step reaching zero.
module bus_wait_timer #(
  parameter int unsigned W = 3
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         i_clear,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_count,
  output logic         o_done
);
  logic [W-1:0] r_cnt;

  always_ff @(posedge clock) begin
    if (reset || i_clear) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_count && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_done = (r_cnt == W'(1));
endmodule

// File: rtl/bus_mem_port.sv
// Byte-array target on a multiplexed address/data bus with programmable wait states.
module bus_mem_port
  import bus_pkg::*;
#(
  parameter int unsigned       ADDR_W      = ADDR_W_DEF,
  parameter int unsigned       DEPTH_W     = 12,
  parameter logic [ADDR_W-1:0] BASE        = '0,
  parameter bit                IO_SPACE    = 1'b0,
  parameter int unsigned       WAIT_STATES = 0,
  parameter bit                ON          = 1'b1
) (
  input logic           clock,
  input logic           reset,
  bus_mem_port_if.slave bus
);
  localparam int unsigned MEM_BYTES = 2 ** DEPTH_W;

  if (DEPTH_W < 1 || DEPTH_W >= ADDR_W) begin : g_bad_depth
    $error("bus_mem_port: DEPTH_W must lie in 1..ADDR_W-1");
  end
  if (BASE[DEPTH_W-1:0] != '0) begin : g_bad_base
    $error("bus_mem_port: BASE must be aligned to 2**DEPTH_W");
  end
  if (WAIT_STATES > MAX_WAIT) begin : g_bad_wait
    $error("bus_mem_port: WAIT_STATES must be 0..7");
  end

  typedef logic [MEM_BYTES-1:0][7:0] mem_t;

  function automatic mem_t mem_init();
    mem_t m;
    for (int unsigned i = 0; i < MEM_BYTES; i++) m[i] = 8'(i);
    return m;
  endfunction

  // Identity pattern visible from time zero; reset deliberately leaves contents alone.
  mem_t r_mem = mem_init();

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic              r_iom;
  logic              r_is_wr;
  logic [7:0]        r_ad;
  logic              r_oe;
  logic              r_rdy;
  logic              r_err;

  logic [DEPTH_W-1:0] w_off;
  logic               w_hit;
  logic               w_rd;
  logic               w_wr;
  logic               w_both;
  logic               w_one;
  logic               w_held;
  logic               w_we;
  logic               w_t_clear;
  logic               w_t_load;
  logic               w_t_count;
  logic               w_t_done;

  assign w_off  = r_addr[DEPTH_W-1:0];
  assign w_hit  = ON && (r_addr[ADDR_W-1:DEPTH_W] == BASE[ADDR_W-1:DEPTH_W]) &&
                  (r_iom == (IO_SPACE ? IOM_IO : IOM_MEM));
  assign w_rd   = !bus.RD;
  assign w_wr   = !bus.WR;
  assign w_both = w_rd && w_wr;
  assign w_one  = w_rd ^ w_wr;
  assign w_held = r_is_wr ? w_wr : w_rd;

  assign w_t_clear = bus.ALE || ((r_state != S_ARMED) && (r_state != S_WAIT));
  assign w_t_load  = (r_state == S_ARMED) && w_hit && w_one;
  assign w_t_count = (r_state == S_WAIT);

  bus_wait_timer #(.W(3)) u_timer (
    .clock      (clock),
    .reset      (reset),
    .i_clear    (w_t_clear),
    .i_load     (w_t_load),
    .i_load_val (3'(WAIT_STATES)),
    .i_count    (w_t_count),
    .o_done     (w_t_done)
  );

  // Single write per access: only the DATA edge with the write strobe still alone.
  assign w_we = !bus.ALE && (r_state == S_DATA) && r_is_wr && w_wr && !w_rd;

  always_ff @(posedge clock) begin
    if (!reset && w_we) r_mem[w_off] <= bus.AD_i;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_iom   <= 1'b0;
      r_is_wr <= 1'b0;
      r_ad    <= '0;
      r_oe    <= 1'b0;
      r_rdy   <= 1'b1;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (bus.ALE) begin
        r_addr  <= {bus.A, bus.AD_i};
        r_iom   <= bus.IOM;
        r_state <= S_ARMED;
        r_oe    <= 1'b0;
        r_rdy   <= 1'b1;
      end else begin
        case (r_state)
          S_ARMED: begin
            if (w_hit && w_both) begin
              r_err   <= 1'b1;
              r_state <= S_IDLE;
            end else if (w_hit && w_one) begin
              r_is_wr <= w_wr;
              if (WAIT_STATES == 0) begin
                r_state <= S_DATA;
                r_oe    <= w_rd;
                r_ad    <= r_mem[w_off];
              end else begin
                r_state <= S_WAIT;
                r_rdy   <= 1'b0;
              end
            end
          end
          S_WAIT: begin
            if (w_both) begin
              r_err   <= 1'b1;
              r_rdy   <= 1'b1;
              r_state <= S_IDLE;
            end else if (!w_held) begin
              r_rdy   <= 1'b1;
              r_state <= S_IDLE;
            end else if (w_t_done) begin
              r_rdy   <= 1'b1;
              r_oe    <= !r_is_wr;
              r_ad    <= r_mem[w_off];
              r_state <= S_DATA;
            end
          end
          S_DATA: begin
            if (w_both) begin
              r_err   <= 1'b1;
              r_oe    <= 1'b0;
              r_state <= S_IDLE;
            end else if (!w_held) begin
              r_oe    <= 1'b0;
              r_state <= S_IDLE;
            end else if (r_is_wr) begin
              r_state <= S_HOLD;
            end
          end
          S_HOLD: begin
            if (!w_wr) r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.AD_o  = r_ad;
  assign bus.AD_oe = r_oe;
  assign bus.RDY   = r_rdy;
  assign bus.ERR   = r_err;
endmodule

// File: tb/tb_bus_mem_port.sv
// Four port configurations share one bus master; each is checked against an access-level model.
module tb_bus_mem_port;
  localparam int N = 4;
  localparam int WS_T [N] = '{0, 3, 2, 0};
  localparam bit IO_T [N] = '{1'b0, 1'b0, 1'b1, 1'b0};
  localparam bit ON_T [N] = '{1'b1, 1'b1, 1'b1, 1'b0};
  localparam logic [19:0] BASE_T [N] = '{20'h00000, 20'h00000, 20'h05000, 20'h00000};
  localparam int K_RD = 0, K_WR = 1, K_BOTH = 2;

  logic        clock, reset;
  logic        ALE, IOM, RD, WR;
  logic [11:0] A;
  logic [7:0]  AD_m;
  logic [7:0]  ad_o  [N];
  logic        ad_oe [N];
  logic        rdy   [N];
  logic        err   [N];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  for (genvar g = 0; g < N; g++) begin : g_dut
    bus_mem_port_if #(.ADDR_W(20)) u_if ();
    assign u_if.ALE  = ALE;
    assign u_if.IOM  = IOM;
    assign u_if.RD   = RD;
    assign u_if.WR   = WR;
    assign u_if.A    = A;
    assign u_if.AD_i = AD_m;
    assign ad_o[g]   = u_if.AD_o;
    assign ad_oe[g]  = u_if.AD_oe;
    assign rdy[g]    = u_if.RDY;
    assign err[g]    = u_if.ERR;
    bus_mem_port #(
      .ADDR_W(20), .DEPTH_W(12), .BASE(BASE_T[g]), .IO_SPACE(IO_T[g]),
      .WAIT_STATES(WS_T[g]), .ON(ON_T[g])
    ) u_dut (
      .clock(clock), .reset(reset), .bus(u_if)
    );
  end

  int checks = 0;
  int errors = 0;
  logic [7:0] mdl [N][4096];
  int         meas_rl  [N];
  int         meas_err [N];
  bit         meas_dv  [N];
  logic [7:0] meas_d   [N];

  task automatic chk(input string name, input int n, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s dut%0d: got 0x%0h, expected 0x%0h", name, n, got, exp);
    end
  endtask

  function automatic bit hits(input int n, input logic [19:0] addr, input logic iom);
    int unsigned a, b;
    a = addr;
    b = BASE_T[n];
    return ON_T[n] && (a >= b) && (a < b + 4096) && (iom == (IO_T[n] ? 1'b0 : 1'b1));
  endfunction

  // Address phase, then strobe(s) low for len sampled edges, then two edges with strobes high.
  task automatic xact(input logic [19:0] addr, input logic iom, input int kind,
                      input int len, input logic [7:0] wd);
    bit h [N];
    int off [N];
    for (int n = 0; n < N; n++) begin
      h[n] = hits(n, addr, iom);
      off[n] = int'(addr - BASE_T[n]) & 32'hFFF;
      meas_rl[n] = 0; meas_err[n] = 0; meas_dv[n] = 0; meas_d[n] = '0;
    end
    ALE = 1'b1; IOM = iom; A = addr[19:8]; AD_m = addr[7:0];
    @(posedge clock); #1;
    ALE = 1'b0;
    AD_m = (kind == K_WR) ? wd : 8'($urandom);
    RD = (kind == K_WR) ? 1'b1 : 1'b0;
    WR = (kind == K_RD) ? 1'b1 : 1'b0;
    for (int j = 0; j < len + 2; j++) begin
      @(posedge clock); #1;
      for (int n = 0; n < N; n++) begin
        int ws, lowc;
        bit e_rdy, e_oe, e_err;
        ws = WS_T[n];
        lowc = (len < ws) ? len : ws;
        e_rdy = 1'b1; e_oe = 1'b0; e_err = 1'b0;
        if (h[n]) begin
          if (kind == K_BOTH) e_err = (j == 0);
          else begin
            e_rdy = !(j < lowc);
            e_oe  = (kind == K_RD) && (j >= ws) && (j < len);
          end
        end
        chk("rdy", n, int'(rdy[n]), int'(e_rdy));
        chk("ad_oe", n, int'(ad_oe[n]), int'(e_oe));
        chk("err", n, int'(err[n]), int'(e_err));
        if (e_oe) chk("rdata", n, int'(ad_o[n]), int'(mdl[n][off[n]]));
        if (!rdy[n]) meas_rl[n]++;
        if (err[n]) meas_err[n]++;
        if (ad_oe[n] && !meas_dv[n]) begin
          meas_dv[n] = 1'b1;
          meas_d[n] = ad_o[n];
        end
      end
      if (j == len - 1) begin
        RD = 1'b1; WR = 1'b1;
      end
    end
    for (int n = 0; n < N; n++)
      if (h[n] && kind == K_WR && len >= WS_T[n] + 2) mdl[n][off[n]] = wd;
  endtask

  typedef struct {
    logic [19:0] addr;
    logic        iom;
    int          kind;
    int          len;
    logic [7:0]  wd;
    logic [2:0]  dmask;
    logic [7:0]  ed0, ed1, ed2;
    int          rl0, rl1, rl2;
    logic [2:0]  emask;
  } vec_t;

  vec_t tbl [18];

  initial begin
    reset = 1'b1; ALE = 1'b0; IOM = 1'b1; RD = 1'b1; WR = 1'b1; A = '0; AD_m = '0;
    for (int n = 0; n < N; n++)
      for (int i = 0; i < 4096; i++) mdl[n][i] = 8'(i);

    tbl[0]  = '{20'h00012, 1'b1, K_RD,   5, 8'h00, 3'b011, 8'h12, 8'h12, 8'h00, 0, 3, 0, 3'b000};
    tbl[1]  = '{20'h00034, 1'b1, K_WR,   6, 8'hA5, 3'b000, 8'h00, 8'h00, 8'h00, 0, 3, 0, 3'b000};
    tbl[2]  = '{20'h00034, 1'b1, K_RD,   5, 8'h00, 3'b011, 8'hA5, 8'hA5, 8'h00, 0, 3, 0, 3'b000};
    tbl[3]  = '{20'h05010, 1'b1, K_RD,   5, 8'h00, 3'b000, 8'h00, 8'h00, 8'h00, 0, 0, 0, 3'b000};
    tbl[4]  = '{20'h05010, 1'b0, K_RD,   5, 8'h00, 3'b100, 8'h00, 8'h00, 8'h10, 0, 0, 2, 3'b000};
    tbl[5]  = '{20'h01000, 1'b1, K_RD,   5, 8'h00, 3'b000, 8'h00, 8'h00, 8'h00, 0, 0, 0, 3'b000};
    tbl[6]  = '{20'h00FFF, 1'b1, K_RD,   5, 8'h00, 3'b011, 8'hFF, 8'hFF, 8'h00, 0, 3, 0, 3'b000};
    tbl[7]  = '{20'h00020, 1'b1, K_BOTH, 3, 8'h99, 3'b000, 8'h00, 8'h00, 8'h00, 0, 0, 0, 3'b011};
    tbl[8]  = '{20'h00020, 1'b1, K_RD,   5, 8'h00, 3'b011, 8'h20, 8'h20, 8'h00, 0, 3, 0, 3'b000};
    tbl[9]  = '{20'h05FFF, 1'b0, K_WR,   6, 8'h5A, 3'b000, 8'h00, 8'h00, 8'h00, 0, 0, 2, 3'b000};
    tbl[10] = '{20'h05FFF, 1'b0, K_RD,   5, 8'h00, 3'b100, 8'h00, 8'h00, 8'h5A, 0, 0, 2, 3'b000};
    tbl[11] = '{20'h06000, 1'b0, K_RD,   5, 8'h00, 3'b000, 8'h00, 8'h00, 8'h00, 0, 0, 0, 3'b000};
    tbl[12] = '{20'h04FFF, 1'b0, K_RD,   5, 8'h00, 3'b000, 8'h00, 8'h00, 8'h00, 0, 0, 0, 3'b000};
    tbl[13] = '{20'h00040, 1'b1, K_WR,   2, 8'h77, 3'b000, 8'h00, 8'h00, 8'h00, 0, 2, 0, 3'b000};
    tbl[14] = '{20'h00040, 1'b1, K_RD,   5, 8'h00, 3'b011, 8'h77, 8'h40, 8'h00, 0, 3, 0, 3'b000};
    tbl[15] = '{20'h05034, 1'b1, K_WR,   6, 8'hEE, 3'b000, 8'h00, 8'h00, 8'h00, 0, 0, 0, 3'b000};
    tbl[16] = '{20'h05034, 1'b0, K_RD,   5, 8'h00, 3'b100, 8'h00, 8'h00, 8'h34, 0, 0, 2, 3'b000};
    tbl[17] = '{20'h00034, 1'b0, K_RD,   5, 8'h00, 3'b000, 8'h00, 8'h00, 8'h00, 0, 0, 0, 3'b000};

    repeat (3) @(posedge clock);
    #1;
    for (int n = 0; n < N; n++) begin
      chk("reset_rdy", n, int'(rdy[n]), 1);
      chk("reset_err", n, int'(err[n]), 0);
      chk("reset_oe", n, int'(ad_oe[n]), 0);
    end
    reset = 1'b0;
    @(posedge clock); #1;

    for (int v = 0; v < 18; v++) begin
      logic [7:0] ed [3];
      int rl [3];
      ed = '{tbl[v].ed0, tbl[v].ed1, tbl[v].ed2};
      rl = '{tbl[v].rl0, tbl[v].rl1, tbl[v].rl2};
      xact(tbl[v].addr, tbl[v].iom, tbl[v].kind, tbl[v].len, tbl[v].wd);
      for (int n = 0; n < 3; n++) begin
        chk("tbl_rdy_low", n, meas_rl[n], rl[n]);
        chk("tbl_err_cnt", n, meas_err[n], int'(tbl[v].emask[n]));
        if (tbl[v].dmask[n]) chk("tbl_rdata", n, meas_dv[n] ? int'(meas_d[n]) : -1, int'(ed[n]));
      end
    end

    // Reset lands while the WS=3 port waits and before the WS=0 port's write edge.
    ALE = 1'b1; IOM = 1'b1; A = '0; AD_m = 8'h77;
    @(posedge clock); #1;
    ALE = 1'b0; AD_m = 8'h3C; WR = 1'b0;
    @(posedge clock); #1;
    chk("pre_reset_wait", 1, int'(rdy[1]), 0);
    reset = 1'b1;
    @(posedge clock); #1;
    for (int n = 0; n < N; n++) begin
      chk("mid_reset_rdy", n, int'(rdy[n]), 1);
      chk("mid_reset_oe", n, int'(ad_oe[n]), 0);
      chk("mid_reset_err", n, int'(err[n]), 0);
    end
    reset = 1'b0; WR = 1'b1;
    @(posedge clock); #1;
    xact(20'h00077, 1'b1, K_RD, 5, 8'h00);
    chk("reset_nowrite", 0, int'(meas_d[0]), 8'h77);
    chk("reset_nowrite", 1, int'(meas_d[1]), 8'h77);

    for (int t = 0; t < 80; t++) begin
      logic [19:0] a;
      int r, k;
      r = $urandom_range(0, 3);
      case (r)
        0: a = 20'($urandom_range(32'h00000, 32'h0003F));
        1: a = 20'($urandom_range(32'h00FF0, 32'h0100F));
        2: a = 20'($urandom_range(32'h04FF0, 32'h0500F));
        default: a = 20'($urandom_range(32'h05FF0, 32'h0600F));
      endcase
      k = $urandom_range(0, 9);
      xact(a, 1'($urandom_range(0, 1)), (k < 4) ? K_RD : (k < 8) ? K_WR : K_BOTH,
           $urandom_range(1, 7), 8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bus_mem_port.md
BUS_MEM_PORT -- requirements
Module: bus_mem_port

Interface
REQ-001 Parameter ADDR_W, default 20, meaning system address width.
REQ-002 Parameter DEPTH_W, default 12, meaning log2 of local byte array size.
REQ-003 Parameter BASE, default 20'h00000, meaning first decoded address; SHALL be aligned to 2**DEPTH_W.
REQ-004 Parameter IO_SPACE, default 0, meaning 1 = respond to I/O cycles (IOM=0), 0 = memory cycles (IOM=1).
REQ-005 Parameter WAIT_STATES, default 0, range 0..7, meaning wait cycles inserted before data phase.
REQ-006 Parameter ON, default 1, meaning 0 = port never responds (outputs held at reset values).
REQ-007 clock  in  1  single system clock; all state changes on rising edge.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 ALE  in  1  address latch enable, high during T1.
REQ-010 IOM  in  1  1 = memory cycle, 0 = I/O cycle.
REQ-011 RD  in  1  active-low read strobe.
REQ-012 WR  in  1  active-low write strobe.
REQ-013 A  in  ADDR_W-8  upper address bits.
REQ-014 AD  inout  8  multiplexed address/data; high-Z unless driving read data.
REQ-015 RDY  out  1  ready to CPU; 0 = insert wait state.
REQ-016 ERR  out  1  one-cycle pulse on protocol error.

Function
REQ-017 ALE sampled high SHALL latch {A,AD} and IOM into addr_q/iom_q and move FSM to ARMED; ALE in any state restarts the cycle.
REQ-018 Hit SHALL be: BASE <= addr_q < BASE+2**DEPTH_W and iom_q matches IO_SPACE; offset = addr_q[DEPTH_W-1:0].
REQ-019 FSM states: IDLE, ARMED, WAIT, DATA, HOLD.
REQ-020 ARMED, hit, exactly one of RD/WR sampled low: load counter with WAIT_STATES, go WAIT (or DATA directly if WAIT_STATES=0).
REQ-021 ARMED, miss: remain ARMED, never drive AD, RDY stays 1, no write.
REQ-022 WAIT: RDY=0 while counter!=0; decrement each cycle; at 0 go DATA with RDY=1 that same cycle.
REQ-023 DATA read: AD = mem[offset] from the DATA cycle until RD sampled high.
REQ-024 DATA write: mem[offset] <= AD exactly once at the DATA edge; go HOLD.
REQ-025 HOLD/DATA: strobe sampled high -> IDLE, AD released the same cycle.
REQ-026 RD and WR both sampled low in ARMED/WAIT/DATA: ERR=1 one cycle, AD released, no write, go IDLE.
REQ-027 Strobe deasserted during WAIT: abort to IDLE, no write, no ERR.
REQ-028 Total read latency strobe-low to data valid SHALL be WAIT_STATES+1 cycles.

Reset
REQ-029 Reset SHALL force IDLE, AD high-Z, RDY=1, ERR=0, counter=0, addr_q=0.
REQ-030 Reset mid-cycle SHALL abort without a write; array contents SHALL NOT be cleared.
REQ-031 Array SHALL initialise to mem[i] = i[7:0] at time zero for bench visibility.

Structure
REQ-032 Package bus_pkg SHALL hold the FSM state enum, ADDR_W default, and IO/MEM encoding constants.
REQ-033 Wait counter SHALL be a sub-module bus_wait_timer (load, count, done).
REQ-034 Elaboration check SHALL reject misaligned BASE or WAIT_STATES>7.

Verification
REQ-035 WAIT_STATES=0, read 0x00012 (BASE 0) -> AD=0x12 one cycle after RD low, RDY never 0.
REQ-036 WAIT_STATES=3, write 0xA5 to 0x00034 then read -> RDY low exactly 3 cycles each access, readback 0xA5.
REQ-037 IO_SPACE=1, memory cycle to in-range address -> AD stays Z, RDY=1, array unchanged.
REQ-038 Address BASE+2**DEPTH_W -> no response; address BASE+2**DEPTH_W-1 -> responds.
REQ-039 RD and WR low together -> ERR pulses one cycle, no write, AD Z.
REQ-040 Reset asserted during WAIT of a write -> IDLE next cycle, RDY=1, target byte unchanged.
